// File: rtl/mem_responder_pkg.sv
// Shared types for the multi-cycle data-memory responder: FSM state
// encoding, latency counter width and error causes.
package mem_resp_pkg;

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RDWR  = 2'd1,
    ERR_ALIGN = 2'd2
  } err_cause_e;

  // Classify a request; only meaningful while Rd or Wr is asserted.
  function automatic err_cause_e req_cause(input logic rd, input logic wr, input logic a0);
    if (rd && wr) return ERR_RDWR;
    if ((rd || wr) && a0) return ERR_ALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// memory responder (slave).
interface mem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, err
  );
endinterface

// File: rtl/mem_responder_array.sv
// Word-addressed 16-bit storage: synchronous write, registered read that
// only updates on a read access so the last read value is held.
module mem_resp_array #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [0:(1<<AW)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && wr_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (en_i && !wr_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory model behind the MEM stage: accepts one request in
// IDLE, stalls for LATENCY-1 cycles, then pulses Done (and err) for one cycle.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int AW      = 13,
  parameter int LATENCY = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam logic [CW-1:0] LOAD   = CW'(LATENCY - 1);
  localparam bit            DIRECT = (LATENCY == 1);

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic          wr_q;
  logic          done_q;
  logic          stall_q;
  logic          err_q;

  err_cause_e    cause_d;
  logic          req_d;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   rdata;

  // Address bits above AW alias by design; bit 0 only feeds the error check.
  logic unused_addr;
  assign unused_addr = ^bus.Addr;

  always_comb begin
    cause_d = req_cause(bus.Rd, bus.Wr, bus.Addr[0]);
    req_d   = (state_q == S_IDLE) && (bus.Rd || bus.Wr) && (cause_d == ERR_NONE);
    // With LATENCY=1 the access happens on the accepting edge, straight from the bus.
    if (DIRECT) begin
      mem_en    = rst && req_d;
      mem_wr    = bus.Wr;
      mem_addr  = bus.Addr[AW:1];
      mem_wdata = bus.DataIn;
    end else begin
      mem_en    = rst && (state_q == S_BUSY) && (count_q == CW'(1));
      mem_wr    = wr_q;
      mem_addr  = addr_q;
      mem_wdata = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          stall_q <= 1'b0;
          if (bus.Rd || bus.Wr) begin
            if (cause_d != ERR_NONE) begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              addr_q  <= bus.Addr[AW:1];
              data_q  <= bus.DataIn;
              wr_q    <= bus.Wr;
              count_q <= LOAD;
              if (DIRECT) begin
                state_q <= S_RESP;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_BUSY;
                stall_q <= 1'b1;
              end
            end
          end
        end
        S_BUSY: begin
          if (count_q == CW'(1)) begin
            state_q <= S_RESP;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            count_q <= '0;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  mem_resp_array #(.AW(AW)) u_array (
    .clk     (clk),
    .rst     (rst),
    .en_i    (mem_en),
    .wr_i    (mem_wr),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (rdata)
  );

  assign bus.DataOut = rdata;
  assign bus.Done    = done_q;
  assign bus.Stall   = stall_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance for the main flows
// and a LATENCY=1 instance for the direct-access path.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mem_responder_if bus();
  mem_responder_if bus1();

  mem_responder #(.AW(13), .LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.AW(13), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] data);
    if (sel) begin
      bus1.Rd = rd; bus1.Wr = wr; bus1.Addr = addr; bus1.DataIn = data;
    end else begin
      bus.Rd = rd; bus.Wr = wr; bus.Addr = addr; bus.DataIn = data;
    end
  endtask

  task automatic sample(input bit sel, output logic d, output logic s,
                        output logic e, output logic [15:0] o);
    if (sel) begin
      d = bus1.Done; s = bus1.Stall; e = bus1.err; o = bus1.DataOut;
    end else begin
      d = bus.Done; s = bus.Stall; e = bus.err; o = bus.DataOut;
    end
  endtask

  // One request from IDLE; lat is the sample index (cycles after the
  // accepting edge, starting at 1) where Done is first seen.
  task automatic do_req(input bit sel, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] data,
                        output int lat, output int stalls, output logic errv,
                        output logic [15:0] dout, output logic done_after,
                        output logic [15:0] dout_after);
    logic seen, d, s, e;
    logic [15:0] o;
    seen = 1'b0; lat = 99; stalls = 0; errv = 1'b0; dout = '0;
    done_after = 1'b0; dout_after = '0;
    drive(sel, rd, wr, addr, data);
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (i == 1) drive(sel, 1'b0, 1'b0, 16'hFFFE, 16'h0000);
      sample(sel, d, s, e, o);
      if (s) stalls++;
      if (d) begin
        seen = 1'b1; lat = i; errv = e; dout = o;
      end
    end
    if (seen) begin
      tick();
      sample(sel, d, s, e, o);
      done_after = d; dout_after = o;
    end
    $display("txn dut%0d rd=%0b wr=%0b addr=%h data=%h -> lat=%0d stalls=%0d err=%0b dout=%h",
             sel ? 1 : 4, rd, wr, addr, data, lat, stalls, errv, dout);
  endtask

  int          lat, st, pulses, first, second;
  logic        ev, da, seen;
  logic [15:0] dv, doa, hd;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) tick();
    check("rst_done",  bus.Done,     1'b0);
    check("rst_stall", bus.Stall,    1'b0);
    check("rst_err",   bus.err,      1'b0);
    check("rst_dout",  bus.DataOut,  16'h0);
    check("rst_dout1", bus1.DataOut, 16'h0);
    rst = 1'b1;
    tick();

    // Write then read back, LATENCY=4
    do_req(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, st, ev, dv, da, doa);
    check("wr_lat", lat, 4);
    check("wr_stalls", st, 3);
    check("wr_err", ev, 1'b0);
    check("wr_done_drop", da, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, st, ev, dv, da, doa);
    check("rd_lat", lat, 4);
    check("rd_data", dv, 16'hBEEF);
    check("rd_held", doa, 16'hBEEF);
    check("rd_done_drop", da, 1'b0);

    // Held read: new access every LATENCY+1 cycles, BUSY-time changes ignored
    do_req(1'b0, 1'b0, 1'b1, 16'h0020, 16'h5A5A, lat, st, ev, dv, da, doa);
    check("wr20_lat", lat, 4);
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    pulses = 0; first = 0; second = 0; hd = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 2) begin bus.Addr = 16'h0010; bus.Rd = 1'b0; end
      if (i == 3) begin bus.Addr = 16'h0020; bus.Rd = 1'b1; end
      if (bus.Done) begin
        pulses++;
        if (pulses == 1) begin first = i; hd = bus.DataOut; end
        else if (pulses == 2) second = i;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    $display("txn dut4 held rd addr=0020 -> pulses=%0d first=%0d second=%0d dout=%h",
             pulses, first, second, hd);
    check("held_pulses", pulses, 2);
    check("held_first", first, 4);
    check("held_gap", second - first, 5);
    check("held_data", hd, 16'h5A5A);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.Done) seen = 1'b1;
    end
    check("held_drain", seen, 1'b1);
    tick();

    // Errors: Rd&Wr and misaligned write leave memory and DataOut alone
    do_req(1'b0, 1'b0, 1'b1, 16'h0004, 16'h0404, lat, st, ev, dv, da, doa);
    check("wr04_lat", lat, 4);
    do_req(1'b0, 1'b1, 1'b1, 16'h0004, 16'h1111, lat, st, ev, dv, da, doa);
    check("rdwr_lat", lat, 1);
    check("rdwr_err", ev, 1'b1);
    check("rdwr_stalls", st, 0);
    check("rdwr_dout", dv, 16'h5A5A);
    check("rdwr_err_drop", da, 1'b0);
    do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, lat, st, ev, dv, da, doa);
    check("rd04_data", dv, 16'h0404);
    check("rd04_err", ev, 1'b0);
    do_req(1'b0, 1'b0, 1'b1, 16'h0011, 16'hDEAD, lat, st, ev, dv, da, doa);
    check("align_lat", lat, 1);
    check("align_err", ev, 1'b1);
    check("align_dout", dv, 16'h0404);
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, st, ev, dv, da, doa);
    check("rd10_after_align", dv, 16'hBEEF);

    // Address wrap above AW
    do_req(1'b0, 1'b0, 1'b1, 16'h4000, 16'hA5A5, lat, st, ev, dv, da, doa);
    do_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, lat, st, ev, dv, da, doa);
    check("wrap_data", dv, 16'hA5A5);

    // Reset in the middle of a write
    do_req(1'b0, 1'b0, 1'b1, 16'h0030, 16'h7777, lat, st, ev, dv, da, doa);
    drive(1'b0, 1'b0, 1'b1, 16'h0030, 16'h9999);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    check("pre_rst_stall", bus.Stall, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("arst_done",  bus.Done,    1'b0);
    check("arst_stall", bus.Stall,   1'b0);
    check("arst_err",   bus.err,     1'b0);
    check("arst_dout",  bus.DataOut, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.Done) pulses++;
    end
    $display("txn dut4 reset mid-write addr=0030 -> done pulses after release=%0d", pulses);
    check("arst_no_done", pulses, 0);
    do_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, lat, st, ev, dv, da, doa);
    check("arst_no_write", dv, 16'h7777);

    // LATENCY=1 instance
    do_req(1'b1, 1'b0, 1'b1, 16'h0002, 16'h1234, lat, st, ev, dv, da, doa);
    check("l1_wr_lat", lat, 1);
    check("l1_wr_stalls", st, 0);
    check("l1_wr_err", ev, 1'b0);
    do_req(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, lat, st, ev, dv, da, doa);
    check("l1_rd_lat", lat, 1);
    check("l1_rd_stalls", st, 0);
    check("l1_rd_data", dv, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
